// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for the processor's instruction memory (DEPTH words x DW bits).
// Consumes a byte-wide valid/ready stream with this layout:
//   N (word count, 1..DEPTH), then 4*N data bytes (big-endian, MSB first),
//   then an optional checksum byte (XOR of all data bytes).
// Each completed word is written to memory with a one-cycle wr_en pulse.
// The processor is held in reset (cpu_hold) until a load completes successfully.
//
// Build option:
//   LOADER_CHECKSUM_EN - when defined, a trailing checksum byte is required and
//                        checked; a mismatch ends the load in the error state.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   single-cycle pulse; begins a load from IDLE/DONE/ERR
//   in_valid   in   stream byte valid
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte this cycle
//   wr_en      out  instruction memory write strobe (one cycle per word)
//   wr_addr    out  word address being written
//   wr_data    out  word being written
//   cpu_hold   out  holds the processor in reset while not successfully loaded
//   busy       out  loader is consuming a stream (LEN/DATA/CSUM)
//   done       out  last load completed successfully (level)
//   err        out  last load aborted (level)
//   word_count out  words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_r;
    logic [AW:0]     len_r;        // latched word count N
    logic [1:0]      byte_cnt_r;   // byte position inside the current word
    logic [DW-1:0]   asm_r;        // word assembly shift register
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_r;       // running XOR of all data bytes
`endif

    logic            hs_s;
    logic            len_ok_s;
    logic [DW-1:0]   word_next_s;
    logic [AW:0]     cnt_inc_s;

    // Handshake, length validation and next-word helpers.
    assign hs_s        = in_valid & in_ready;
    assign len_ok_s    = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(DEPTH));
    assign word_next_s = {asm_r[DW-9:0], in_data};
    assign cnt_inc_s   = word_count + (AW+1)'(1);

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            len_r      <= '0;
            byte_cnt_r <= 2'd0;
            asm_r      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            wr_en <= 1'b0;

            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_r    <= S_LEN;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        byte_cnt_r <= 2'd0;
                        asm_r      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_r     <= 8'd0;
`endif
                    end
                end

                S_LEN: begin
                    if (hs_s) begin
                        if (len_ok_s) begin
                            // N <= DEPTH is known here, so AW+1 bits hold it.
                            len_r   <= in_data[AW:0];
                            state_r <= S_DATA;
                        end else begin
                            state_r  <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (hs_s) begin
                        asm_r      <= word_next_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_r     <= csum_r ^ in_data;
`endif
                        if (byte_cnt_r == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= word_count[AW-1:0];
                            wr_data    <= word_next_s;
                            word_count <= cnt_inc_s;
                            if (cnt_inc_s == len_r) begin
`ifdef LOADER_CHECKSUM_EN
                                state_r  <= S_CSUM;
`else
                                state_r  <= S_DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (hs_s) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum_r) begin
                            state_r  <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            // Words already written stay in memory; CPU stays held.
                            state_r  <= S_ERR;
                            err      <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader. Memory writes are logged by a
// monitor and compared against hand-computed address/data sequences.
// Works with or without LOADER_CHECKSUM_EN defined.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    int            chk_cnt;
    int            pass_cnt;
    logic [7:0]    csum_b;
    bit            stall_en;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    imem_loader #(.DEPTH(16), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every memory write, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    // Hard time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", tag, obs, exp);
    endtask

    // Called at posedge+1; start is sampled at the next edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present a byte and hold it until the handshake edge; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (stall_en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
            csum_b = csum_b ^ w[i*8 +: 8];
        end
    endtask

    // Checksum byte when the option is built in; nothing otherwise.
    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_b);
`endif
    endtask

    task automatic begin_load(input logic [7:0] n);
        log_addr.delete();
        log_data.delete();
        csum_b = 8'd0;
        pulse_start();
        send_byte(n);
    endtask

    task automatic verify_log(input string tag, input int n, input logic [31:0] base, input logic [31:0] step);
        check({tag, "_nwr"}, log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check({tag, "_addr"}, {28'd0, log_addr[i]}, i);
            check({tag, "_data"}, log_data[i], base + step * i);
        end
    endtask

    task automatic check_done(input string tag, input int n);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wc"}, {27'd0, word_count}, n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_wren"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_addr"}, {28'd0, wr_addr}, 32'd0);
        check({tag, "_data"}, wr_data, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"},  {31'd0, err}, 32'd0);
        check({tag, "_wc"},   {27'd0, word_count}, 32'd0);
    endtask

    initial begin
        int nlog;
        chk_cnt  = 0;
        pass_cnt = 0;
        stall_en = 1'b0;
        csum_b   = 8'd0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        reset    = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // ---- Basic two-word load ----
        log_addr.delete();
        log_data.delete();
        csum_b = 8'd0;
        pulse_start();
        check("basic_rdy_len", {31'd0, in_ready}, 32'd1);
        check("basic_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h02);
        send_word(32'h00000D10);
        send_word(32'h00004D11);
`ifndef LOADER_CHECKSUM_EN
        // Final write and DONE land in the same cycle.
        check("basic_last_wren", {31'd0, wr_en}, 32'd1);
        check("basic_last_addr", {28'd0, wr_addr}, 32'd1);
`else
        check("basic_csum_model", {24'd0, csum_b}, 32'h41);
`endif
        finish_load();
        check_done("basic", 2);
        repeat (2) @(posedge clk); #1;
        verify_log("basic", 2, 32'h00000D10, 32'h00004001);

        // ---- Bad length: 0 and 17 ----
        begin_load(8'h00);
        check("len0_err", {31'd0, err}, 32'd1);
        check("len0_hold", {31'd0, cpu_hold}, 32'd1);
        check("len0_rdy", {31'd0, in_ready}, 32'd0);
        check("len0_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk); #1;
        check("len0_nwr", log_addr.size(), 32'd0);
        begin_load(8'h11);
        check("len17_err", {31'd0, err}, 32'd1);
        check("len17_hold", {31'd0, cpu_hold}, 32'd1);
        check("len17_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk); #1;
        check("len17_nwr", log_addr.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // ---- Checksum good / bad ----
        begin_load(8'h01);
        send_word(32'h12345678);
        check("csum_model", {24'd0, csum_b}, 32'h08);
        send_byte(8'h08);
        check_done("csum_ok", 1);
        begin_load(8'h01);
        send_word(32'h12345678);
        send_byte(8'h09);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
        check("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
        repeat (2) @(posedge clk); #1;
        verify_log("csum_bad", 1, 32'h12345678, 32'd0);
`endif

        // ---- Full depth with stalls ----
        stall_en = 1'b1;
        begin_load(8'h10);
        for (int i = 0; i < 16; i++) send_word(32'hA0B0C0D0 + 32'h01010101 * i);
        finish_load();
        stall_en = 1'b0;
        check_done("full", 16);
        repeat (3) @(posedge clk); #1;
        verify_log("full", 16, 32'hA0B0C0D0, 32'h01010101);

        // ---- Reset mid-load after the 6th byte ----
        begin_load(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'h55 + 8'(i));
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        nlog = log_addr.size();
        check("midrst_prior_wr", nlog, 32'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("midrst_no_wr", log_addr.size(), nlog);
        begin_load(8'h03);
        for (int i = 0; i < 3; i++) send_word(32'h11223344 + 32'h01010101 * i);
        finish_load();
        check_done("after_rst", 3);
        repeat (2) @(posedge clk); #1;
        verify_log("after_rst", 3, 32'h11223344, 32'h01010101);

        // ---- Start while busy is ignored ----
        begin_load(8'h02);
        send_word(32'hCAFE0000);
        pulse_start();
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        check("busy_start_wc", {27'd0, word_count}, 32'd1);
        send_word(32'hCAFE0001);
        finish_load();
        check_done("busy_start", 2);
        repeat (2) @(posedge clk); #1;
        verify_log("busy_start", 2, 32'hCAFE0000, 32'd1);

        // Bytes offered in DONE are not consumed.
        in_valid = 1'b1;
        in_data  = 8'h07;
        @(negedge clk);
        check("done_no_rdy", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the processor's 16-word × 32-bit instruction memory from a byte-wide valid/ready stream. It is the write side of instruction memory, while the datapath's fetch is the read side. The loader holds the processor in reset while loading, packs bytes into words, issues one write per word, and reports done or error.

## Interface
- `DEPTH`, 16: instruction memory depth in words.
- `AW`, 4: write address width; DEPTH must equal 2**AW.
- `DW`, 32: instruction word width; must be 32.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `start`  in  1: single-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
- `in_valid`  in  1: byte valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `wr_en`  out  1: instruction memory write strobe, one cycle per word.
- `wr_addr`  out  AW: word address being written.
- `wr_data`  out  DW: word being written.
- `cpu_hold`  out  1: holds the processor in reset; asserted while a load is in progress.
- `busy`  out  1: loader is in LEN, DATA or CSUM.
- `done`  out  1: load completed successfully; level signal.
- `err`  out  1: load aborted; level signal.
- `word_count`  out  AW+1: number of words written in the current or last load.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start` → LEN. On this transition, `word_count` clears, `done` and `err` clear, and the byte counter and checksum clear.
- **LEN:** `in_ready`=1. The first transferred byte is N, the word count.
  - If 1 ≤ N ≤ DEPTH: latch N and go to DATA.
  - Otherwise (N=0 or N>DEPTH): go to ERR.
- **DATA:** `in_ready`=1. Bytes are big-endian, MSB first; 4 bytes form one word, shifted into a 32-bit assembly register.
- On the 4th byte of a word:
  - `wr_en` pulses the next cycle with `wr_addr` = `word_count`[AW-1:0] and `wr_data` = the assembled word.
  - `word_count` increments in that same cycle.
- Addresses run 0..N-1 and never wrap, because N ≤ DEPTH is enforced.
- After word N-1 is written: go to CSUM if `LOADER_CHECKSUM_EN` is defined, else go to DONE.
- **CSUM:** `in_ready`=1. One byte is compared to the XOR of all 4N data bytes.
  - Match → DONE.
  - Mismatch → ERR. Words already written remain in memory.
- **DONE:** `done`=1 and `cpu_hold`=0; the processor runs.
- **ERR:** `err`=1 and `cpu_hold`=1; the processor stays held until a successful load.
- `start` in LEN, DATA or CSUM is ignored, with no restart.
- `in_valid` held low stalls indefinitely; there is no timeout.

## Timing
- Reset values:
  - State=IDLE.
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `cpu_hold`=1, `busy`=0, `done`=0, `err`=0, `word_count`=0.
  - The assembly register and checksum are 0.
- `start` at edge k puts the loader in LEN with `in_ready`=1 from cycle k+1.
- Throughput is 1 byte/cycle. `wr_en` is asserted exactly 1 cycle after the handshake of each word's 4th byte.
- `in_ready` stays 1 during the `wr_en` cycle, so no bubbles are inserted.
- Leaving DATA or CSUM is registered on the final byte's handshake edge:
  - `done`/`err` are visible the next cycle.
  - `cpu_hold` falls in that same cycle.
- The final word's `wr_en` and the transition to DONE occur in the same cycle (checksum disabled).
- `in_ready`=0 in IDLE, DONE and ERR. Bytes presented there are not consumed.
- Reset asserted mid-load returns all outputs to their reset values immediately. The partial word is discarded, and no `wr_en` is issued for it.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - A running XOR of the data bytes is kept.
  - A trailing checksum byte is required, and a mismatch yields ERR.
- `LOADER_CHECKSUM_EN` undefined:
  - There is no CSUM state and no checksum register.
  - The stream is exactly 1 + 4N bytes, and DATA goes straight to DONE after the last write.

## Test plan
- **Basic two-word load (no macro):** `start`, then bytes 02, 00,00,0D,10, 00,00,4D,11.
  - `wr_en` at addr 0 with data 0x00000D10, then addr 1 with data 0x00004D11.
  - `word_count`=2, `done`=1, `cpu_hold`=0.
- **Bad length:** `start`, then byte 00 gives `err`=1, `cpu_hold`=1, no `wr_en`. Repeating with byte 11 (17) gives the same result.
- **Checksum (macro):** N=1, word 0x12345678.
  - Checksum byte 0x08 → `done`.
  - Checksum byte 0x09 → `err`, with the word still written to addr 0.
- **Full depth with stalls:** N=16 with `in_valid` randomly deasserted.
  - Exactly 16 writes, at addresses 0..15, in order.
  - `word_count`=16, no wrap.
- **Reset mid-load:** assert reset after the 6th byte.
  - All outputs return to reset values at once.
  - No further `wr_en`.
  - A subsequent `start` with a full stream loads correctly.
- **Start while busy:** `start` pulsed in DATA is ignored; the load completes with the original N and addresses.
